seven_seg_scanner: RTL and testbench

Downstream consumer of the 2-bit digit-select counter: takes the free-running digit index and a 16-bit hex value and drives the four-digit, common-anode seven-segment display. It resynchronises the digit index, inserts a blanking interval on every digit change to prevent ghosting, and latches new display values tear-free. Leading zeros are optionally suppressed. All outputs are registered and active-low.

---
 rtl/seven_seg_scanner.sv | 151 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode 7-segment scanner: resyncs the digit index,
// blanks on digit change, tear-free value update, leading-zero blanking.
// Ports: clock, reset_n, digit_sel[1:0], value[15:0], dp_mask[3:0],
//        load, enable -> an[3:0], seg[6:0], dp, pending (all active-low
//        display outputs except pending, all registered).
module seven_seg_scanner #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending
);

  typedef enum logic {BLANK, DRIVE} state_e;

  localparam logic [7:0] CNT_INIT = 8'(BLANK_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  s1_q, s2_q;
  logic [1:0]  cur_q, cur_d;
  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic        pend_q, pend_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        xfer;
  logic [3:0]  nib;
  logic        lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    xfer    = 1'b0;
    unique case (state_q)
      DRIVE: begin
        if (s2_q != cur_q) begin
          state_d = BLANK;
          cnt_d   = CNT_INIT;
          xfer    = 1'b1;
        end
      end
      BLANK: begin
        // Index changes during the blank do not restart it;
        // whatever is sampled at exit is the digit driven.
        if (cnt_q == 8'd0) begin
          state_d = DRIVE;
          cur_d   = s2_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
    if (!enable) xfer = 1'b1;

    // Shadow equals disp whenever nothing is pending, so an
    // unconditional copy on transfer is harmless.
    disp_val_d = xfer ? sh_val_q : disp_val_q;
    disp_dp_d  = xfer ? sh_dp_q  : disp_dp_q;
    sh_val_d   = load ? value    : sh_val_q;
    sh_dp_d    = load ? dp_mask  : sh_dp_q;
    pend_d     = load ? 1'b1 : (xfer ? 1'b0 : pend_q);

    nib = disp_val_d[{cur_d, 2'b00} +: 4];
    lz  = LZ_SUPPRESS && (cur_d != 2'd0)
          && ((disp_val_d >> {cur_d, 2'b00}) == 16'h0);

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (enable && state_d == DRIVE) begin
      an_d  = ~(4'b0001 << cur_d);
      seg_d = lz ? 7'h7F : hex7(nib);
      dp_d  = ~disp_dp_d[cur_d];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BLANK;
      cnt_q      <= CNT_INIT;
      s1_q       <= 2'd0;
      s2_q       <= 2'd0;
      cur_q      <= 2'd0;
      sh_val_q   <= 16'h0;
      sh_dp_q    <= 4'h0;
      disp_val_q <= 16'h0;
      disp_dp_q  <= 4'h0;
      pend_q     <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_q       <= digit_sel;
      s2_q       <= s1_q;
      cur_q      <= cur_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random traffic
// checked each cycle against a behavioural display model.
module tb_seven_seg_scanner;

  localparam int BC = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  digit_sel = 2'd0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;

  seven_seg_scanner #(
    .BLANK_CYCLES(BC),
    .LZ_SUPPRESS(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .digit_sel(digit_sel),
    .value(value),
    .dp_mask(dp_mask),
    .load(load),
    .enable(enable),
    .an(an),
    .seg(seg),
    .dp(dp),
    .pending(pending)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: a digit is lit from the edge blank_end onward; reset behaves
  // like a digit change just before the first edge.
  int         t;
  int         blank_end;
  bit         lit;
  int         cur;
  int         samp [$];
  int         m_shadow, m_disp, m_sdp, m_ddp;
  bit         m_pend;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    blank_end = BC;
    lit = 0;
    cur = 0;
    samp = {};
    samp.push_back(0);
    samp.push_back(0);
    m_shadow = 0; m_disp = 0; m_sdp = 0; m_ddp = 0;
    m_pend = 0;
  endtask

  task automatic check_outputs(input bit en);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         upper;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (lit && en) begin
      upper = m_disp >> (4 * cur);
      e_an  = 4'(~(1 << cur));
      e_seg = (cur != 0 && upper == 0) ? 7'h7F : hex_tbl[upper % 16];
      e_dp  = ((m_ddp >> cur) & 1) == 0;
    end
    check("an", {12'h0, an}, {12'h0, e_an});
    check("seg", {9'h0, seg}, {9'h0, e_seg});
    check("dp", {15'h0, dp}, {15'h0, e_dp});
    check("pending", {15'h0, pending}, {15'h0, m_pend});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [1:0] s, input logic ld,
                      input logic [15:0] v, input logic [3:0] m,
                      input logic e);
    int  seen;
    bit  change;
    digit_sel = s; load = ld; value = v; dp_mask = m; enable = e;
    @(posedge clock);
    t++;
    samp.push_back(int'(s));
    seen = samp[samp.size() - 3];
    change = 0;
    if (lit) begin
      if (seen != cur) begin
        lit = 0;
        blank_end = t + BC;
        change = 1;
      end
    end else if (t == blank_end) begin
      cur = seen;
      lit = 1;
    end
    if (change || !e) begin
      m_disp = m_shadow;
      m_ddp  = m_sdp;
      m_pend = 0;
    end
    if (ld) begin
      m_shadow = int'(v);
      m_sdp    = int'(m);
      m_pend   = 1;
    end
    #1;
    check_outputs(e);
    @(negedge clock);
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    load = 1'b0;
    #1;
    check("rst_an", {12'h0, an}, 16'hF);
    check("rst_seg", {9'h0, seg}, 16'h7F);
    check("rst_dp", {15'h0, dp}, 16'h1);
    check("rst_pend", {15'h0, pending}, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [1:0] ds;
    logic [1:0] order [4];
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    model_reset();
    @(negedge clock);
    do_reset();

    // Boot: four dark cycles, then digit 0 showing zero.
    hold(2'd0, BC);
    check("boot_an", {12'h0, an}, 16'b1110);
    check("boot_seg", {9'h0, seg}, 16'b1000000);

    // 12A8 walk over all digits.
    order   = '{2'd1, 2'd2, 2'd3, 2'd0};
    an_exp  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_exp = '{7'b0001000, 7'b0100100, 7'b1111001, 7'b0000000};
    step(2'd0, 1'b1, 16'h12A8, 4'b0100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      hold(order[k], 10);
      check("walk_an", {12'h0, an}, {12'h0, an_exp[k]});
      check("walk_seg", {9'h0, seg}, {9'h0, seg_exp[k]});
      check("walk_dp", {15'h0, dp}, {15'h0, (k != 1)});
    end

    // Two loads while driving digit 1; the second wins.
    hold(2'd1, 10);
    step(2'd1, 1'b1, 16'h1111, 4'h0, 1'b1);
    hold(2'd1, 2);
    step(2'd1, 1'b1, 16'h2222, 4'h0, 1'b1);
    hold(2'd1, 5);
    check("pend_hold", {15'h0, pending}, 16'h1);
    hold(2'd2, 10);
    check("second_seg", {9'h0, seg}, 16'b0100100);

    // Leading-zero blanking with 0050.
    step(2'd2, 1'b1, 16'h0050, 4'h0, 1'b1);
    hold(2'd3, 10);
    hold(2'd2, 10);
    hold(2'd1, 10);
    check("lz_d1", {9'h0, seg}, 16'b0010010);
    hold(2'd0, 10);

    // Several toggles inside one blank interval.
    hold(2'd1, 2);
    hold(2'd2, 2);
    hold(2'd3, 12);
    check("toggle_an", {12'h0, an}, 16'b0111);

    // Load while dark, then re-enable with no blank.
    hold(2'd0, 10);
    step(2'd0, 1'b1, 16'hFFFF, 4'h0, 1'b0);
    step(2'd0, 1'b0, 16'h0, 4'h0, 1'b0);
    check("dark_pend", {15'h0, pending}, 16'h0);
    step(2'd0, 1'b0, 16'h0, 4'h0, 1'b1);
    check("wake_seg", {9'h0, seg}, 16'b0001110);

    // Random traffic with occasional mid-run resets.
    ds = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) ds = 2'($urandom_range(0, 3));
        step(ds, 1'($urandom_range(0, 9) == 0),
             16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3))),
             4'($urandom_range(0, 15)),
             1'($urandom_range(0, 19) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
